type2_slink_rxfb: RTL

TYPE2_SLINK_RXFB -- requirements
Module: type2_slink_rxfb

---
 rtl/type2_slink_rxfb.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/type2_slink_rxfb.sv
// Receive frame buffer for a type-2 serial link: stores whole frames and
// exposes a word only after its frame has been committed by a good EOF.
module type2_slink_rxfb #(
    parameter int unsigned BUF_AW      = 9,
    parameter int unsigned MAX_FRM_LEN = 256
) (
    input  logic        clk_100m,
    input  logic        rst_100m,
    input  logic        rx_dval,
    input  logic [17:0] rx_data,
    input  logic        rx_crc_err,
    input  logic        mm_slink_rdreq,
    output logic        slink_mm_empty,
    output logic        slink_mm_dval,
    output logic [17:0] slink_mm_data,
    output logic [15:0] frm_drop_cnt,
    output logic        buf_ovf
);

    localparam int unsigned DW    = 18;
    localparam int unsigned DEPTH = 1 << BUF_AW;
    localparam int unsigned PTR_W = BUF_AW + 1;
    localparam int unsigned LEN_W = $clog2(MAX_FRM_LEN + 1);

    localparam logic [1:0] TAG_SOF = 2'b10;
    localparam logic [1:0] TAG_EOF = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_DROP
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0]   commit_ptr, commit_ptr_nxt;
    logic [PTR_W-1:0]   rd_ptr, rd_ptr_nxt;
    logic [LEN_W-1:0]   len, len_nxt;
    logic               we_c;
    logic [BUF_AW-1:0]  waddr_c;
    logic               drop_c;
    logic               ovf_c;
    logic               rd_fire_c;
    logic               is_sof_c;
    logic               is_eof_c;
    logic               full_wr_c;
    logic               full_commit_c;

    logic [DW-1:0]      mem [DEPTH];

    // Word classification and occupancy seen by the write side
    always_comb begin
        is_sof_c      = (rx_data[17:16] == TAG_SOF);
        is_eof_c      = (rx_data[17:16] == TAG_EOF);
        full_wr_c     = ((wr_ptr - rd_ptr) == PTR_W'(DEPTH));
        full_commit_c = ((commit_ptr - rd_ptr) == PTR_W'(DEPTH));
    end

    // Write FSM next state, pointer updates and write strobe
    always_comb begin
        state_nxt      = state;
        wr_ptr_nxt     = wr_ptr;
        commit_ptr_nxt = commit_ptr;
        len_nxt        = len;
        we_c           = 1'b0;
        waddr_c        = wr_ptr[BUF_AW-1:0];
        drop_c         = 1'b0;
        ovf_c          = 1'b0;

        case (state)
            ST_IDLE, ST_DROP: begin
                if (rx_dval) begin
                    if (is_sof_c) begin
                        if (full_commit_c) begin
                            // No room even for the SOF; count it once on entry to DROP
                            wr_ptr_nxt = commit_ptr;
                            state_nxt  = ST_DROP;
                            if (state == ST_IDLE) begin
                                ovf_c  = 1'b1;
                                drop_c = 1'b1;
                            end
                        end else begin
                            we_c       = 1'b1;
                            waddr_c    = commit_ptr[BUF_AW-1:0];
                            wr_ptr_nxt = commit_ptr + PTR_W'(1);
                            len_nxt    = LEN_W'(1);
                            state_nxt  = ST_RECV;
                        end
                    end else if ((state == ST_DROP) && is_eof_c) begin
                        state_nxt = ST_IDLE;
                    end
                end
            end

            ST_RECV: begin
                if (rx_dval) begin
                    if (is_sof_c) begin
                        // Abort the partial frame and restart on this SOF
                        drop_c     = 1'b1;
                        wr_ptr_nxt = commit_ptr;
                        if (full_commit_c) begin
                            ovf_c     = 1'b1;
                            state_nxt = ST_DROP;
                        end else begin
                            we_c       = 1'b1;
                            waddr_c    = commit_ptr[BUF_AW-1:0];
                            wr_ptr_nxt = commit_ptr + PTR_W'(1);
                            len_nxt    = LEN_W'(1);
                        end
                    end else if (is_eof_c && rx_crc_err) begin
                        drop_c     = 1'b1;
                        wr_ptr_nxt = commit_ptr;
                        state_nxt  = ST_IDLE;
                    end else if (len >= LEN_W'(MAX_FRM_LEN)) begin
                        // Overlong frame; an overlong EOF already ends it
                        drop_c     = 1'b1;
                        wr_ptr_nxt = commit_ptr;
                        state_nxt  = is_eof_c ? ST_IDLE : ST_DROP;
                    end else if (full_wr_c) begin
                        ovf_c      = 1'b1;
                        drop_c     = 1'b1;
                        wr_ptr_nxt = commit_ptr;
                        state_nxt  = is_eof_c ? ST_IDLE : ST_DROP;
                    end else begin
                        // Body, reserved tag or good EOF: store it
                        we_c       = 1'b1;
                        wr_ptr_nxt = wr_ptr + PTR_W'(1);
                        len_nxt    = len + LEN_W'(1);
                        if (is_eof_c) begin
                            commit_ptr_nxt = wr_ptr + PTR_W'(1);
                            state_nxt      = ST_IDLE;
                        end
                    end
                end
            end

            default: begin
                state_nxt  = ST_IDLE;
                wr_ptr_nxt = commit_ptr;
            end
        endcase
    end

    // Read request is honoured only against committed data
    always_comb begin
        rd_fire_c  = mm_slink_rdreq & ~slink_mm_empty;
        rd_ptr_nxt = rd_ptr + PTR_W'(rd_fire_c);
    end

    // Write-side state, pointers and drop statistics
    always_ff @(posedge clk_100m or posedge rst_100m) begin
        if (rst_100m) begin
            state        <= ST_IDLE;
            wr_ptr       <= '0;
            commit_ptr   <= '0;
            len          <= '0;
            frm_drop_cnt <= 16'h0;
            buf_ovf      <= 1'b0;
        end else begin
            state      <= state_nxt;
            wr_ptr     <= wr_ptr_nxt;
            commit_ptr <= commit_ptr_nxt;
            len        <= len_nxt;
            buf_ovf    <= ovf_c;
            if (drop_c && (frm_drop_cnt != 16'hFFFF)) begin
                frm_drop_cnt <= frm_drop_cnt + 16'd1;
            end
        end
    end

    // Buffer storage; contents are not reset
    always_ff @(posedge clk_100m) begin
        if (we_c) begin
            mem[waddr_c] <= rx_data;
        end
    end

    // Read side: pointer, empty flag and registered read data
    always_ff @(posedge clk_100m or posedge rst_100m) begin
        if (rst_100m) begin
            rd_ptr         <= '0;
            slink_mm_empty <= 1'b1;
            slink_mm_dval  <= 1'b0;
            slink_mm_data  <= 18'h0;
        end else begin
            rd_ptr         <= rd_ptr_nxt;
            slink_mm_empty <= (rd_ptr_nxt == commit_ptr_nxt);
            slink_mm_dval  <= rd_fire_c;
            if (rd_fire_c) begin
                slink_mm_data <= mem[rd_ptr[BUF_AW-1:0]];
            end
        end
    end

endmodule
